fetch_unit: RTL

- Parametrised next-generation instruction fetch stage: holds the PC, reads the combinational instructionMemory, and buffers {pc, instruction} pairs in a small fetch queue.
- Presents a valid/ready interface to decode, so decode back-pressure stalls fetch without losing instructions.
- Accepts a redirect (branch/jump target) from execute that flushes the queue and restarts fetch at the new PC.
- Sits between the PC-select logic and the decode stage; replaces the free-running PC+4 fetch.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 67 ++++++
 rtl/instructionMemory.sv | 33 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Fetch-stage shared definitions.
// FETCH_XLEN / FETCH_ILEN are the default datapath widths.
// fetch_entry_t is the {pc, instr} pair held in the fetch queue at those
// default widths.
package fetch_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 64;
  localparam int FETCH_ILEN  = FETCH_XLEN / 2;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched {pc, instr} entries.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           drop every entry (pointers and count cleared)
//   push, din       write an entry; accepted when not full, or when full
//                   and popping in the same cycle
//   pop             drop the head; ignored when empty
//   dout            head entry, forced to zero when empty
//   count           number of entries held, 0..DEPTH
//   full, empty     status flags
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_e, pop_e;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign pop_e  = pop & ~empty;
  // A full queue still accepts a write when the head leaves this cycle.
  assign push_e = push & (~full | pop_e);
  assign dout   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_e, pop_e})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_e) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_e)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push_e && !(rst || flush)) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/instructionMemory.sv
// Combinational-read instruction store with a synchronous debug write port.
// Ports:
//   clk                       clock for debug writes
//   addr, instr               word-aligned fetch address and read data
//   dbg_wr_en, dbg_addr,      debug write (preload) port
//   dbg_instr
// Only address bits [IW+1:2] select a word; higher bits alias.
module instructionMemory #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int WORDS = 256
) (
  input  logic            clk,
  input  logic [XLEN-1:0] addr,
  output logic [ILEN-1:0] instr,
  input  logic            dbg_wr_en,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [ILEN-1:0] dbg_instr
);
  localparam int IW = $clog2(WORDS);

  logic [ILEN-1:0] mem_q [WORDS];

  assign instr = mem_q[addr[IW+1:2]];

  always_ff @(posedge clk) begin
    if (dbg_wr_en) mem_q[dbg_addr[IW+1:2]] <= dbg_instr;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[XLEN-1:IW+2], addr[1:0],
                              dbg_addr[XLEN-1:IW+2], dbg_addr[1:0]};
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction memory and a small
// fetch queue presenting {pc, instruction} to decode over valid/ready.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   redirect_valid/_pc         flush queue and restart fetch at target
//   out_valid/_ready/_pc/      queue head handshake to decode
//   out_instruction
//   misaligned_redirect        one-cycle pulse for a redirect with pc[1:0]!=0
//   fetch_pc                   current fetch PC
//   dbg_wr_en/_addr/_instr     instruction memory preload passthrough
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN               = FETCH_XLEN,
  parameter int               INSTRUCTION_LENGTH = XLEN / 2,
  parameter logic [XLEN-1:0]  RESET_PC           = '0,
  parameter int               QUEUE_DEPTH        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [INSTRUCTION_LENGTH-1:0] out_instruction,
  output logic                          misaligned_redirect,
  output logic [XLEN-1:0]               fetch_pc,
  input  logic                          dbg_wr_en,
  input  logic [XLEN-1:0]               dbg_addr,
  input  logic [INSTRUCTION_LENGTH-1:0] dbg_instr
);
  localparam int EW = XLEN + INSTRUCTION_LENGTH;

  logic [XLEN-1:0]               fetch_pc_q, fetch_pc_d;
  logic                          misaligned_q;
  logic [INSTRUCTION_LENGTH-1:0] mem_instr;
  logic [EW-1:0]                 q_dout;
  logic [$clog2(QUEUE_DEPTH):0]  q_count;
  logic                          q_full, q_empty;
  logic                          deq, enq;

  instructionMemory #(
    .XLEN (XLEN),
    .ILEN (INSTRUCTION_LENGTH)
  ) u_imem (
    .clk       (clk),
    .addr      (fetch_pc_q),
    .instr     (mem_instr),
    .dbg_wr_en (dbg_wr_en),
    .dbg_addr  (dbg_addr),
    .dbg_instr (dbg_instr)
  );

  // Redirect wins over both queue ports: nothing enters or leaves that cycle.
  assign deq = out_valid & out_ready & ~redirect_valid;
  assign enq = ~rst & ~redirect_valid & (~q_full | deq);

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (enq),
    .pop   (deq),
    .din   ({fetch_pc_q, mem_instr}),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (enq)
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      misaligned_q <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  assign out_valid           = ~q_empty;
  assign out_pc              = q_dout[EW-1:INSTRUCTION_LENGTH];
  assign out_instruction     = q_dout[INSTRUCTION_LENGTH-1:0];
  assign misaligned_redirect = misaligned_q;
  assign fetch_pc            = fetch_pc_q;

  logic unused_cnt;
  assign unused_cnt = ^q_count;
endmodule
